// File: rtl/fractal_sync_mp_rx_if.sv
// Merged request channel from the multi-port rx datapath towards the parent tree level.
// The master drives valid and payload; the slave answers with ready.
interface fractal_sync_mp_rx_if #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned AGGR_W  = 4,
    parameter int unsigned ID_W    = 8,
    parameter int unsigned SRC_W   = 2,
    localparam int unsigned PORT_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
);
    logic              valid;
    logic              ready;
    logic [AGGR_W-2:0] aggr;
    logic [ID_W-1:0]   id;
    logic [SRC_W+1:0]  src;
    logic [PORT_W-1:0] port;

    modport master (output valid, aggr, id, src, port, input ready);
    modport slave  (input valid, aggr, id, src, port, output ready);
endinterface

// File: rtl/fractal_sync_mp_rx.sv
// Multi-port rx datapath: per-port sample, local/propagate filter, source tagging and FIFO,
// merged onto one valid/ready channel by a round-robin arbiter that holds its grant while stalled.
module fractal_sync_mp_rx #(
    parameter int unsigned N_PORTS    = 2,
    parameter int unsigned AGGR_W     = 4,
    parameter int unsigned ID_W       = 8,
    parameter int unsigned SRC_W      = 2,
    parameter bit          COMB_IN    = 1'b0,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [N_PORTS-1:0][1:0] SD_MASKS = {2'b10, 2'b01},
    localparam int unsigned PORT_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_PORTS-1:0]          sync_i,
    input  logic [N_PORTS*AGGR_W-1:0]   aggr_i,
    input  logic [N_PORTS*ID_W-1:0]     id_i,
    input  logic [N_PORTS*SRC_W-1:0]    src_i,
    output logic [N_PORTS-1:0]          local_o,
    output logic [N_PORTS-1:0]          root_o,
    output logic [N_PORTS-1:0]          overflow_o,
    input  logic                        err_clr_i,
    output logic [N_PORTS*LVL_W-1:0]    level_o,
    fractal_sync_mp_rx_if.master        req_if
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned ENTRY_W = (AGGR_W - 1) + ID_W + SRC_W + 2;

    if (N_PORTS < 1) begin : g_chk_ports
        $fatal(1, "fractal_sync_mp_rx: N_PORTS must be >= 1");
    end
    if (AGGR_W < 2) begin : g_chk_aggr
        $fatal(1, "fractal_sync_mp_rx: AGGR_W must be >= 2");
    end
    if (FIFO_DEPTH < 1) begin : g_chk_depth
        $fatal(1, "fractal_sync_mp_rx: FIFO_DEPTH must be >= 1");
    end

    logic [N_PORTS-1:0][AGGR_W-1:0]  aggr_in;
    logic [N_PORTS-1:0][ID_W-1:0]    id_in;
    logic [N_PORTS-1:0][SRC_W-1:0]   src_in;
    logic [N_PORTS-1:0]              s_sync;
    logic [N_PORTS-1:0][AGGR_W-1:0]  s_aggr;
    logic [N_PORTS-1:0][ID_W-1:0]    s_id;
    logic [N_PORTS-1:0][SRC_W-1:0]   s_src;

    assign aggr_in = aggr_i;
    assign id_in   = id_i;
    assign src_in  = src_i;

    if (COMB_IN) begin : g_comb_in
        assign s_sync = sync_i;
        assign s_aggr = aggr_in;
        assign s_id   = id_in;
        assign s_src  = src_in;
    end else begin : g_reg_in
        logic [N_PORTS-1:0]             sync_q;
        logic [N_PORTS-1:0][AGGR_W-1:0] aggr_q;
        logic [N_PORTS-1:0][ID_W-1:0]   id_q;
        logic [N_PORTS-1:0][SRC_W-1:0]  src_q;

        // sync is a one-cycle pulse, so the stage reloads every cycle rather than holding
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sync_q <= '0;
                aggr_q <= '0;
                id_q   <= '0;
                src_q  <= '0;
            end else begin
                sync_q <= sync_i;
                aggr_q <= aggr_in;
                id_q   <= id_in;
                src_q  <= src_in;
            end
        end

        assign s_sync = sync_q;
        assign s_aggr = aggr_q;
        assign s_id   = id_q;
        assign s_src  = src_q;
    end

    logic [N_PORTS-1:0]              push;
    logic [N_PORTS-1:0]              push_ok;
    logic [N_PORTS-1:0]              pop;
    logic [N_PORTS-1:0]              ovf_set;
    logic [N_PORTS-1:0]              nonempty;
    logic [N_PORTS-1:0][ENTRY_W-1:0] entry;
    logic [N_PORTS-1:0][ENTRY_W-1:0] head;
    logic [N_PORTS-1:0]              overflow_q;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
        logic [PTR_W-1:0]   wr_q;
        logic [PTR_W-1:0]   rd_q;
        logic [LVL_W-1:0]   cnt_q;
        logic               full;

        assign local_o[p] = s_sync[p] & s_aggr[p][0];
        assign root_o[p]  = s_sync[p] & (s_aggr[p] == AGGR_W'(1));
        assign push[p]    = s_sync[p] & ~s_aggr[p][0];
        assign entry[p]   = {s_aggr[p][AGGR_W-1:1], s_id[p], s_src[p], SD_MASKS[p]};

        // A full FIFO still accepts a push when the same cycle pops it
        assign full       = (cnt_q == LVL_W'(FIFO_DEPTH));
        assign push_ok[p] = push[p] & (~full | pop[p]);
        assign ovf_set[p] = push[p] & full & ~pop[p];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push_ok[p]) begin
                    mem_q[wr_q] <= entry[p];
                    wr_q        <= (wr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
                end
                if (pop[p]) begin
                    rd_q <= (rd_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
                end
                cnt_q <= cnt_q + LVL_W'(push_ok[p]) - LVL_W'(pop[p]);
            end
        end

        assign head[p]     = mem_q[rd_q];
        assign nonempty[p] = (cnt_q != '0);
        assign level_o[p*LVL_W +: LVL_W] = cnt_q;
    end

    // Set takes priority over a coincident clear so no overflow event is lost
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= ovf_set | (overflow_q & ~{N_PORTS{err_clr_i}});
        end
    end

    assign overflow_o = overflow_q;

    logic [PORT_W-1:0]  rr_q;
    logic [PORT_W-1:0]  grant_q;
    logic               lock_q;
    logic [PORT_W-1:0]  arb_grant;
    logic [PORT_W-1:0]  arb_idx;
    logic               arb_found;
    logic [PORT_W-1:0]  grant;
    logic               req_valid;
    logic               hs;
    logic [ENTRY_W-1:0] head_sel;

    always_comb begin
        arb_grant = rr_q;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            arb_idx = PORT_W'((32'(rr_q) + i) % N_PORTS);
            if (!arb_found && nonempty[arb_idx]) begin
                arb_found = 1'b1;
                arb_grant = arb_idx;
            end
        end
    end

    assign req_valid = |nonempty;
    assign grant     = lock_q ? grant_q : arb_grant;
    assign hs        = req_valid & req_if.ready;

    always_comb begin
        pop = '0;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            pop[p] = hs && (grant == PORT_W'(p));
        end
    end

    // A stalled grant is frozen so the payload stays stable until the parent accepts it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q    <= '0;
            grant_q <= '0;
            lock_q  <= 1'b0;
        end else begin
            lock_q  <= req_valid & ~req_if.ready;
            grant_q <= grant;
            if (hs) begin
                rr_q <= (grant == PORT_W'(N_PORTS - 1)) ? '0 : grant + PORT_W'(1);
            end
        end
    end

    assign head_sel     = head[grant];
    assign req_if.valid = req_valid;
    assign req_if.aggr  = head_sel[ENTRY_W-1 -: AGGR_W-1];
    assign req_if.id    = head_sel[SRC_W+2 +: ID_W];
    assign req_if.src   = head_sel[SRC_W+1:0];
    assign req_if.port  = grant;

endmodule
